uart_tx_fsm: RTL and testbench
==============================

UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning serial payload bits per frame.
REQ-002 SHALL have port CLK  input  1  oversampled clock, rising-edge active.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to send.
REQ-005 SHALL have port DATA_VALID  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  parity bit inserted when 1.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 SHALL have port prescale  input  6  CLK cycles per serial bit.
REQ-009 SHALL have port TX_OUT  output  1  serial line, idle high, registered.
REQ-010 SHALL have port BUSY  output  1  frame in progress, registered.

Function
REQ-011 SHALL implement states IDLE, STRT, DATA, PAR, STP.
REQ-012 In IDLE: TX_OUT = 1, BUSY = 0.
REQ-013 SHALL accept a request at a rising edge where state = IDLE and DATA_VALID = 1.
REQ-014 At the accepting edge: latch P_DATA, PAR_EN, PAR_TYP and prescale; enter STRT; TX_OUT = 0; BUSY = 1. Latency from DATA_VALID sampled high to start bit: zero extra cycles.
REQ-015 Every bit SHALL last exactly the latched prescale count of CLK cycles. A latched value of 0 SHALL be treated as 1.
REQ-016 A bit counter (edge_cnt, 6 bits) SHALL count 0..prescale-1. At the terminal count it SHALL wrap to 0 and the FSM SHALL advance to the next bit.
REQ-017 STRT SHALL drive 0 for one bit time, then go to DATA.
REQ-018 DATA SHALL drive bits LSB first, DATA_WIDTH bits, tracked by bit_cnt 0..DATA_WIDTH-1. After the last bit: go to PAR if latched PAR_EN = 1, else to STP.
REQ-019 PAR SHALL drive XOR(latched data) XOR latched PAR_TYP for one bit time, then go to STP.
REQ-020 STP SHALL drive 1 for one bit time.
REQ-021 At the end of the STP bit with DATA_VALID = 1: accept new data at that same edge and go straight to STRT; BUSY stays 1; no idle bit is inserted.
REQ-022 At the end of the STP bit with DATA_VALID = 0: go to IDLE; BUSY = 0 at that edge.
REQ-023 DATA_VALID SHALL be ignored in STRT, DATA and PAR, and in STP before the terminal count.
REQ-024 Changes to P_DATA, PAR_EN, PAR_TYP or prescale during a frame SHALL have no effect on that frame.
REQ-025 Total frame length SHALL be (DATA_WIDTH+2+PAR_EN) x prescale cycles.
REQ-026 Unreachable state encodings SHALL return to IDLE with TX_OUT = 1.
REQ-027 TX_OUT and BUSY SHALL come directly from flops, with no combinational path from any input.

Reset
REQ-028 While RST = 0: state = IDLE, TX_OUT = 1, BUSY = 0, counters = 0, latched registers = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately. After RST deasserts, the next frame SHALL start only on a new DATA_VALID.

Structure
REQ-030 Package uart_tx_pkg SHALL hold the state_t enum (IDLE, STRT, DATA, PAR, STP, Gray-coded 3 bits) and constants START_BIT = 0 and STOP_BIT = 1.
REQ-031 The bit-period counter SHALL be a sub-module, uart_tx_bit_timer. Inputs: clear, enable, prescale. Output: bit_done pulse.
REQ-032 Parity SHALL be computed once from the latched data and registered at acceptance.

Verification
REQ-033 0xA5, PAR_EN = 1, PAR_TYP = 0, prescale = 8 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; BUSY high for 88 cycles.
REQ-034 0x00, PAR_EN = 1, PAR_TYP = 1, prescale = 16 -> parity bit 1; frame is 176 cycles.
REQ-035 0xFF, PAR_EN = 0, prescale = 4 -> 0, then eight 1s, then stop 1; 40 cycles; BUSY then drops.
REQ-036 Back-to-back: 0x3C then 0xC3 with DATA_VALID held high, PAR_EN = 0, prescale = 8 -> the second start bit begins at cycle 80 with no idle gap; BUSY stays high for 160 cycles.
REQ-037 RST pulsed low in DATA bit 3 -> TX_OUT = 1 and BUSY = 0 asynchronously; no output until the next DATA_VALID. Separately, prescale = 0 -> each bit lasts 1 cycle.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding, line levels and bit-timing helper for the UART transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    STRT = 3'b001,
    DATA = 3'b011,
    PAR  = 3'b010,
    STP  = 3'b110
  } state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  // a prescale of 0 behaves as 1, so the terminal count saturates at 0
  function automatic logic [5:0] bit_term(input logic [5:0] ps);
    return ps == 6'd0 ? 6'd0 : ps - 6'd1;
  endfunction
endpackage

// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: parallel request side and serial line of the UART transmitter
interface uart_tx_fsm_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic DATA_VALID;
  logic PAR_EN;
  logic PAR_TYP;
  logic [5:0] prescale;
  logic TX_OUT;
  logic BUSY;
  modport master(output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale, input TX_OUT, BUSY);
  modport slave(input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale, output TX_OUT, BUSY);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts CLK cycles within one serial bit and pulses bit_done on the last one
module uart_tx_bit_timer
  import uart_tx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic       enable,
  input  logic [5:0] prescale,
  output logic       bit_done
);
  logic [5:0] edge_cnt;
  assign bit_done = enable && edge_cnt == bit_term(prescale);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) edge_cnt <= '0;
    else edge_cnt <= (clear || !enable || bit_done) ? 6'd0 : edge_cnt + 6'd1;
endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: frames a parallel word as start, LSB-first data, optional parity and stop bits
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic CLK,
  input logic RST,
  uart_tx_fsm_if.slave bus
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_t state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BW-1:0] bit_cnt;
  logic [5:0] ps_q;
  logic par_en_q;
  logic par_q;
  logic bit_done;
  logic accept;
  // a request is taken when idle or exactly as the stop bit ends, giving gapless back-to-back frames
  assign accept = bus.DATA_VALID && (state == IDLE || (state == STP && bit_done));
  uart_tx_bit_timer timer (
    .CLK(CLK),
    .RST(RST),
    .clear(accept),
    .enable(state != IDLE),
    .prescale(ps_q),
    .bit_done(bit_done)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      bus.TX_OUT <= STOP_BIT;
      bus.BUSY <= 1'b0;
      data_q <= '0;
      bit_cnt <= '0;
      ps_q <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
    end else if (accept) begin
      state <= STRT;
      bus.TX_OUT <= START_BIT;
      bus.BUSY <= 1'b1;
      data_q <= bus.P_DATA;
      bit_cnt <= '0;
      ps_q <= bus.prescale;
      par_en_q <= bus.PAR_EN;
      par_q <= ^bus.P_DATA ^ bus.PAR_TYP;
    end else case (state)
      STRT: if (bit_done) begin
        state <= DATA;
        bus.TX_OUT <= data_q[0];
        data_q <= data_q >> 1;
      end
      // data_q shifts right so the next bit to send is always at index 0
      DATA: if (bit_done) begin
        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
          state <= par_en_q ? PAR : STP;
          bus.TX_OUT <= par_en_q ? par_q : STOP_BIT;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          bus.TX_OUT <= data_q[0];
          data_q <= data_q >> 1;
        end
      end
      PAR: if (bit_done) begin
        state <= STP;
        bus.TX_OUT <= STOP_BIT;
      end
      STP: if (bit_done) begin
        state <= IDLE;
        bus.TX_OUT <= STOP_BIT;
        bus.BUSY <= 1'b0;
      end
      default: begin
        state <= IDLE;
        bus.TX_OUT <= STOP_BIT;
        bus.BUSY <= 1'b0;
      end
    endcase
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed frame checks for the UART transmitter
module tb_uart_tx_fsm;
  logic CLK;
  logic RST;
  int tests;
  int fails;
  logic tx_log[0:199];
  logic busy_log[0:199];
  uart_tx_fsm_if #(.DATA_WIDTH(8)) bus ();
  uart_tx_fsm #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  // requests one frame, then scrambles the request inputs and pokes DATA_VALID mid-frame
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps, input int n);
    bus.P_DATA = d;
    bus.PAR_EN = pe;
    bus.PAR_TYP = pt;
    bus.prescale = ps;
    bus.DATA_VALID = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      tx_log[k] = bus.TX_OUT;
      busy_log[k] = bus.BUSY;
      if (k == 0) begin
        bus.P_DATA = ~d;
        bus.PAR_EN = ~pe;
        bus.PAR_TYP = ~pt;
        bus.prescale = ps + 6'd3;
        bus.DATA_VALID = 1'b0;
      end else bus.DATA_VALID = (k == 1);
    end
  endtask
  task automatic test_reset;
    bus.DATA_VALID = 1'b1;
    bus.P_DATA = 8'h55;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.prescale = 6'd4;
    RST = 1'b1;
    #2 RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      tests += 2;
      if (bus.TX_OUT !== 1'b1) begin fails++; $display("FAIL reset_tx[%0d]: got %b want 1", k, bus.TX_OUT); end
      if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bus.BUSY); end
    end
    bus.DATA_VALID = 1'b0;
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      tests += 2;
      if (bus.TX_OUT !== 1'b1) begin fails++; $display("FAIL idle_tx[%0d]: got %b want 1", k, bus.TX_OUT); end
      if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL idle_busy[%0d]: got %b want 0", k, bus.BUSY); end
    end
  endtask
  task automatic test_a5_even;
    logic [10:0] exp;
    int nb;
    exp = {1'b1, 1'b0, 8'hA5, 1'b0};
    nb = 0;
    send(8'hA5, 1'b1, 1'b0, 6'd8, 96);
    for (int k = 0; k < 88; k++) begin
      tests++;
      if (tx_log[k] !== exp[k/8]) begin fails++; $display("FAIL a5_tx[%0d]: got %b want %b", k, tx_log[k], exp[k/8]); end
    end
    for (int k = 0; k < 96; k++) nb += int'(busy_log[k] === 1'b1);
    tests += 3;
    if (nb != 88) begin fails++; $display("FAIL a5_busy_len: got %0d want 88", nb); end
    if (busy_log[87] !== 1'b1 || busy_log[88] !== 1'b0) begin fails++; $display("FAIL a5_busy_edge: got %b%b want 10", busy_log[87], busy_log[88]); end
    if (tx_log[88] !== 1'b1) begin fails++; $display("FAIL a5_idle_tx: got %b want 1", tx_log[88]); end
  endtask
  task automatic test_zero_odd;
    logic [10:0] exp;
    int nb;
    exp = {1'b1, 1'b1, 8'h00, 1'b0};
    nb = 0;
    send(8'h00, 1'b1, 1'b1, 6'd16, 184);
    for (int k = 0; k < 176; k++) begin
      tests++;
      if (tx_log[k] !== exp[k/16]) begin fails++; $display("FAIL zero_tx[%0d]: got %b want %b", k, tx_log[k], exp[k/16]); end
    end
    for (int k = 0; k < 184; k++) nb += int'(busy_log[k] === 1'b1);
    tests += 2;
    if (tx_log[159] !== 1'b1) begin fails++; $display("FAIL zero_parity: got %b want 1", tx_log[159]); end
    if (nb != 176) begin fails++; $display("FAIL zero_busy_len: got %0d want 176", nb); end
  endtask
  task automatic test_ff_nopar;
    logic [9:0] exp;
    int nb;
    exp = {1'b1, 8'hFF, 1'b0};
    nb = 0;
    send(8'hFF, 1'b0, 1'b0, 6'd4, 48);
    for (int k = 0; k < 40; k++) begin
      tests++;
      if (tx_log[k] !== exp[k/4]) begin fails++; $display("FAIL ff_tx[%0d]: got %b want %b", k, tx_log[k], exp[k/4]); end
    end
    for (int k = 0; k < 48; k++) nb += int'(busy_log[k] === 1'b1);
    tests += 2;
    if (nb != 40) begin fails++; $display("FAIL ff_busy_len: got %0d want 40", nb); end
    if (busy_log[40] !== 1'b0) begin fails++; $display("FAIL ff_busy_drop: got %b want 0", busy_log[40]); end
  endtask
  task automatic test_back_to_back;
    logic [19:0] exp;
    exp = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    bus.P_DATA = 8'h3C;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.prescale = 6'd8;
    bus.DATA_VALID = 1'b1;
    for (int k = 0; k < 168; k++) begin
      @(negedge CLK);
      tx_log[k] = bus.TX_OUT;
      busy_log[k] = bus.BUSY;
      if (k == 0) bus.P_DATA = 8'hC3;
      if (k == 80) begin
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN = 1'b1;
        bus.prescale = 6'd2;
        bus.P_DATA = 8'h00;
      end
    end
    for (int k = 0; k < 160; k++) begin
      tests += 2;
      if (tx_log[k] !== exp[k/8]) begin fails++; $display("FAIL b2b_tx[%0d]: got %b want %b", k, tx_log[k], exp[k/8]); end
      if (busy_log[k] !== 1'b1) begin fails++; $display("FAIL b2b_busy[%0d]: got %b want 1", k, busy_log[k]); end
    end
    tests += 2;
    if (busy_log[160] !== 1'b0) begin fails++; $display("FAIL b2b_busy_drop: got %b want 0", busy_log[160]); end
    if (tx_log[160] !== 1'b1) begin fails++; $display("FAIL b2b_idle_tx: got %b want 1", tx_log[160]); end
  endtask
  task automatic test_reset_mid_frame;
    send(8'hA5, 1'b1, 1'b0, 6'd8, 34);
    tests += 2;
    if (tx_log[33] !== 1'b0) begin fails++; $display("FAIL mid_pre_tx: got %b want 0", tx_log[33]); end
    if (busy_log[33] !== 1'b1) begin fails++; $display("FAIL mid_pre_busy: got %b want 1", busy_log[33]); end
    #2 RST = 1'b0;
    #1;
    tests += 2;
    if (bus.TX_OUT !== 1'b1) begin fails++; $display("FAIL mid_async_tx: got %b want 1", bus.TX_OUT); end
    if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL mid_async_busy: got %b want 0", bus.BUSY); end
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      tests += 2;
      if (bus.TX_OUT !== 1'b1) begin fails++; $display("FAIL mid_after_tx[%0d]: got %b want 1", k, bus.TX_OUT); end
      if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL mid_after_busy[%0d]: got %b want 0", k, bus.BUSY); end
    end
  endtask
  task automatic test_prescale_zero;
    logic [10:0] exp;
    exp = {1'b1, 1'b0, 8'h5A, 1'b0};
    send(8'h5A, 1'b1, 1'b0, 6'd0, 13);
    for (int k = 0; k < 11; k++) begin
      tests += 2;
      if (tx_log[k] !== exp[k]) begin fails++; $display("FAIL ps0_tx[%0d]: got %b want %b", k, tx_log[k], exp[k]); end
      if (busy_log[k] !== 1'b1) begin fails++; $display("FAIL ps0_busy[%0d]: got %b want 1", k, busy_log[k]); end
    end
    tests += 2;
    if (busy_log[11] !== 1'b0) begin fails++; $display("FAIL ps0_busy_drop: got %b want 0", busy_log[11]); end
    if (tx_log[11] !== 1'b1) begin fails++; $display("FAIL ps0_idle_tx: got %b want 1", tx_log[11]); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_a5_even;
    test_zero_odd;
    test_ff_nopar;
    test_back_to_back;
    test_reset_mid_frame;
    test_prescale_zero;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
